// File: rtl/seq_divider16.sv
// seq_divider16 -- multi-cycle restoring divider (one trial subtraction per cycle).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request, accepted when the unit is IDLE or in its DONE cycle
//   dividend        numerator, sampled with an accepted start
//   divisor         denominator, sampled with an accepted start
//   busy            high while iterating (RUN, and FIX when signed)
//   done            one-cycle pulse; results valid from this cycle on
//   quotient        registered quotient, held until the next done
//   remainder       registered remainder, held until the next done
//   div_by_zero     registered divide-by-zero flag, updated with done
//
// Optional build macro SEQ_DIVIDER16_SIGNED_DIV_EN: two's-complement operands.
// Magnitudes are divided and the result signs are applied in an extra FIX cycle.
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} state_e;

  localparam logic [WIDTH:0]   ONE_R = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH-1);

  state_e           state_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic [WIDTH-1:0] q_q, d_q;
  logic [WIDTH:0]   r_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   r_sh, t, r_d;
  logic [WIDTH-1:0] q_d, mag_n, mag_d, q_zero;
  logic             qbit;

`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
  logic sq_q, sr_q;  // quotient sign, remainder sign (= dividend sign)
`endif

  // One restoring step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor as A + ~B + 1 on WIDTH+1 bits.
  always_comb begin
    r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    t    = r_sh + {1'b1, ~d_q} + ONE_R;
    qbit = ~t[WIDTH];
    r_d  = qbit ? t : r_sh;
    q_d  = {q_q[WIDTH-2:0], qbit};
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
    mag_n  = dividend[WIDTH-1] ? (~dividend + ONE_W) : dividend;
    mag_d  = divisor[WIDTH-1]  ? (~divisor  + ONE_W) : divisor;
    q_zero = dividend[WIDTH-1] ? ONE_W : {WIDTH{1'b1}};
`else
    mag_n  = dividend;
    mag_d  = divisor;
    q_zero = {WIDTH{1'b1}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
            state_q <= FIX;
`else
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
`endif
          end
        end
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= sq_q ? (~q_q + ONE_W) : q_q;
          rem_q   <= sr_q ? (~r_q[WIDTH-1:0] + ONE_W) : r_q[WIDTH-1:0];
        end
`endif
        default: begin  // IDLE or DONE: both accept a new start
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= q_zero;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dz_q    <= 1'b0;
              q_q     <= mag_n;
              d_q     <= mag_d;
              r_q     <= '0;
              cnt_q   <= '0;
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
              sq_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sr_q    <= dividend[WIDTH-1];
`endif
            end
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases plus randomized
// operands checked against a plain-arithmetic reference model.
module tb_seq_divider16;

  localparam int W = 16;
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_chk = 0;
  int n_bad = 0;

  seq_divider16 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: arithmetic straight from the division rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == 0);
`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
    begin
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) begin
        q = (sa >= 0) ? 16'hFFFF : 16'h0001;
        r = a;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end
`else
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endtask

  // Present operands with start for one edge (the accepting edge = edge 1).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
  endtask

  // Waits for done (bounded), checking latency, busy and results.
  task automatic finish_op(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int edges0);
    logic [W-1:0] eq, er;
    logic         edz;
    int           edges;
    bit           busy_ok;
    edges   = edges0;
    busy_ok = 1'b1;
    while (!done && edges < 60) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      edges++;
    end
    model(a, b, eq, er, edz);
    chk({tag, ".lat"}, edges, (b == 0) ? 1 : LAT);
    chk({tag, ".busy_run"}, busy_ok, 1);
    chk({tag, ".busy_done"}, busy, 0);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, div_by_zero, edz);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hq;

    // Reset state.
    rst = 1'b1;
    #2;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.dz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic and boundary cases.
    launch(16'd1000, 16'd7);      finish_op("basic", 16'd1000, 16'd7, 1);
    tick();
    launch(16'hFFFF, 16'd1);      finish_op("max1", 16'hFFFF, 16'd1, 1);
    launch(16'h1234, 16'hFFFF);   finish_op("max2", 16'h1234, 16'hFFFF, 1);
    launch(16'd0, 16'd9);         finish_op("zero_n", 16'd0, 16'd9, 1);
    launch(16'd5, 16'd0);         finish_op("dz", 16'd5, 16'd0, 1);
    launch(16'd9, 16'd3);         finish_op("after_dz", 16'd9, 16'd3, 1);

    // Results held through IDLE, no stray done.
    hq = quotient;
    repeat (3) tick();
    chk("hold.done", done, 0);
    chk("hold.q", quotient, hq);

    // Start re-pulsed mid-RUN is ignored.
    launch(16'd1000, 16'd7);
    repeat (4) tick();
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    tick();
    start = 1'b0;
    finish_op("ignore", 16'd1000, 16'd7, 6);

    // Start in the DONE cycle is accepted back-to-back.
    launch(16'd100, 16'd10);      finish_op("b2b", 16'd100, 16'd10, 1);

    // Reset in mid-RUN aborts and clears results.
    launch(16'd1000, 16'd7);
    repeat (6) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.q", quotient, 0);
    chk("abort.r", remainder, 0);
    tick();
    rst = 1'b0;
    begin
      bit saw_done = 1'b0;
      repeat (20) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      chk("abort.no_done", saw_done, 0);
    end
    launch(16'd1000, 16'd7);      finish_op("post_rst", 16'd1000, 16'd7, 1);

`ifdef SEQ_DIVIDER16_SIGNED_DIV_EN
    launch(16'hFFF9, 16'd2);      finish_op("s_neg7", 16'hFFF9, 16'd2, 1);
    launch(16'h8000, 16'hFFFF);   finish_op("s_minneg", 16'h8000, 16'hFFFF, 1);
    launch(16'hFFF0, 16'd0);      finish_op("s_dz", 16'hFFF0, 16'd0, 1);
`endif

    // Randomized operands, including zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = W'($urandom) >> $urandom_range(0, 15);
        default: rb = W'($urandom);
      endcase
      launch(ra, rb);
      finish_op("rand", ra, rb, 1);
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider16.md
Name: seq_divider16

Overview:
- Multi-cycle unsigned restoring divider for the FIR datapath; the inverse-arithmetic companion to the 16-bit carry-lookahead adder.
- Each iteration performs one trial subtraction (A + ~B + 1) on a WIDTH+1-bit partial remainder.
- Used for gain normalisation and averaging after accumulation.
- Start/busy/done handshake; results are held until the next start is accepted.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (must be >= 2).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH  numerator; sampled with an accepted start.
- divisor  input  WIDTH  denominator; sampled with an accepted start.
- busy  output  1  high in RUN (and FIX) states.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  registered flag; updated together with done.

Behaviour:
- States: IDLE, RUN, DONE (plus FIX with the option). All outputs are registered.
- Reset (async, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- start is accepted on an edge where state is IDLE or DONE, so back-to-back operations are allowed. In RUN, start is ignored and the operands are not resampled.
- Accept, divisor != 0:
  - Load Q=dividend, partial remainder R=0 (WIDTH+1 bits), D=divisor, cnt=0.
  - state->RUN, busy=1, div_by_zero cleared.
- RUN, each edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' - {1'b0, D}.
  - If T[WIDTH]=0: R=T and shift in quotient bit 1. Otherwise: R=R' and shift in 0.
  - Q = {Q[WIDTH-2:0], bit}; cnt++.
  - When cnt reaches WIDTH-1 on this edge: state->DONE.
- DONE cycle:
  - done=1, busy=0, quotient=Q, remainder=R[WIDTH-1:0].
  - Next edge -> IDLE, or -> RUN if a new start is accepted.
- Latency: done is high after WIDTH+1 rising edges, counting the accepting edge as edge 1; 17 edges at the default width.
- Accept, divisor == 0:
  - state->DONE directly; done high after 1 edge.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- quotient, remainder and div_by_zero hold their values through IDLE until the next DONE.
- Boundary cases:
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend=0, divisor!=0: quotient=0, remainder=0, full latency.
  - The subtraction width is WIDTH+1, so there is no overflow for any unsigned operands.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and the prior results are cleared to 0.

Optional Feature:
- Macro: SEQ_DIVIDER16_SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at load; the sign of each result is resolved in an extra FIX state between RUN and DONE, so normal latency is WIDTH+2.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient=0x8000 (at WIDTH=16), remainder=0.
  - Divisor=0 gives quotient = -1 if dividend >= 0, else +1; remainder=dividend; div_by_zero=1.
- Undefined: unsigned only, no FIX state, latency as above.

Test Plan:
- Basic divide: dividend=1000, divisor=7, start for 1 cycle -> done after 17 edges; quotient=142, remainder=6, div_by_zero=0; busy high for edges 1-16.
- Maximum values: dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Then dividend=0x1234, divisor=0xFFFF -> quotient=0, remainder=0x1234.
- Divide by zero: dividend=5, divisor=0 -> done after 1 edge; quotient=0xFFFF, remainder=5, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Handshake: start re-pulsed with new operands mid-RUN -> ignored, original result delivered. A start held high in the DONE cycle with 100/10 -> accepted; next done gives quotient=10, remainder=0.
- Reset: rst pulsed at edge 8 of a 1000/7 operation -> all outputs 0 immediately (asynchronous); no done pulse; the next start works normally.
- With SEQ_DIVIDER16_SIGNED_DIV_EN: -7/2 -> quotient=0xFFFD, remainder=0xFFFF, done after 18 edges. 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
